// File: rtl/fp_mac_ctrl_if.sv
// ---------------------------------------------------------------------------
// fp_mac_ctrl_if
// Groups the signals between the FP MAC sequencing controller, the decode
// stage, the FP multiplier/adder and the register-file write port.
//
//   issue_valid/op/rd/rs/rt  decode -> controller : instruction offered
//   issue_ready, stall       controller -> decode : accept / freeze PC+IF/ID
//   mul_start, add_start     controller -> units  : one-cycle start pulses
//   mul_done, add_done       units -> controller  : one-cycle result pulses
//   add_sel_c                controller -> adder  : operand-B select (1 = c)
//   wb_en, wb_rd             controller -> regfile: write strobe / dest
//   busy, err_illegal, err_timeout  controller status
//
// Modports: slave = the controller, master = the pipeline/unit side.
// ---------------------------------------------------------------------------
interface fp_mac_ctrl_if;
   logic       issue_valid;
   logic [1:0] issue_op;
   logic [4:0] issue_rd;
   logic [4:0] issue_rs;
   logic [4:0] issue_rt;
   logic       issue_ready;
   logic       stall;
   logic       mul_start;
   logic       add_start;
   logic       mul_done;
   logic       add_done;
   logic       add_sel_c;
   logic       wb_en;
   logic [4:0] wb_rd;
   logic       busy;
   logic       err_illegal;
   logic       err_timeout;

   modport slave (
      input  issue_valid, issue_op, issue_rd, issue_rs, issue_rt,
      input  mul_done, add_done,
      output issue_ready, stall, mul_start, add_start, add_sel_c,
      output wb_en, wb_rd, busy, err_illegal, err_timeout
   );

   modport master (
      output issue_valid, issue_op, issue_rd, issue_rs, issue_rt,
      output mul_done, add_done,
      input  issue_ready, stall, mul_start, add_start, add_sel_c,
      input  wb_en, wb_rd, busy, err_illegal, err_timeout
   );
endinterface

// File: rtl/fp_mac_ctrl.sv
// ---------------------------------------------------------------------------
// fp_mac_ctrl
// Sequencing controller for FADD / FMUL / FMAC (a*b+c). It accepts one
// instruction at a time from decode, pulses the multiplier and/or adder,
// waits for their done pulses (bounded by TIMEOUT cycles per unit) and
// issues a one-cycle register-file write. A new instruction may be accepted
// in the write-back cycle when it does not read the register being written.
//
// Ports:
//   clk    system clock, all state changes on its rising edge
//   reset  synchronous, active-low
//   bus    fp_mac_ctrl_if.slave (issue, unit, write-back and status signals)
// Parameter:
//   TIMEOUT  cycles to wait for a unit done before abandoning the operation
// ---------------------------------------------------------------------------
module fp_mac_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   fp_mac_ctrl_if.slave  bus
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   localparam logic [1:0] OP_FADD = 2'b00;
   localparam logic [1:0] OP_FMUL = 2'b01;
   localparam logic [1:0] OP_FMAC = 2'b10;

   typedef enum logic [1:0] {IDLE, MUL, ADD, WB} state_t;

   state_t        state;
   state_t        state_next;
   logic [1:0]    op_q;
   logic [4:0]    rd_q;
   logic [CW-1:0] count;
   logic          ready;
   logic          accept;
   logic          set_illegal;
   logic          set_timeout;
   logic          illegal_q;
   logic          timeout_q;

   // Map an accepted opcode to the state that executes it; the reserved
   // opcode goes straight back to IDLE.
   function automatic state_t dispatch(input logic [1:0] op);
      case (op)
         OP_FADD: return ADD;
         OP_FMUL: return MUL;
         OP_FMAC: return MUL;
         default: return IDLE;
      endcase
   endfunction

   // Ready in IDLE, or in WB when the new instruction does not read the
   // register being written this cycle (no forwarding path exists).
   assign ready  = (state == IDLE) |
                   ((state == WB) & (bus.issue_rs != rd_q) & (bus.issue_rt != rd_q));
   assign accept = bus.issue_valid & ready;

   // Next-state logic. A done pulse is checked before the timeout limit so
   // that a done arriving on the last allowed cycle still completes.
   always_comb begin
      state_next  = state;
      set_timeout = 1'b0;
      set_illegal = accept & (bus.issue_op == 2'b11);
      case (state)
         IDLE: begin
            if (accept) state_next = dispatch(bus.issue_op);
         end
         MUL: begin
            if (bus.mul_done) begin
               state_next = (op_q == OP_FMAC) ? ADD : WB;
            end else if (count == LIMIT) begin
               state_next  = IDLE;
               set_timeout = 1'b1;
            end
         end
         ADD: begin
            if (bus.add_done) begin
               state_next = WB;
            end else if (count == LIMIT) begin
               state_next  = IDLE;
               set_timeout = 1'b1;
            end
         end
         WB: begin
            state_next = accept ? dispatch(bus.issue_op) : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, latched instruction fields, wait counter and sticky errors.
   // The counter restarts on every state change, so it reads zero exactly
   // in the first cycle of MUL or ADD, which is what generates the starts.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         op_q      <= 2'b00;
         rd_q      <= 5'd0;
         count     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_q <= bus.issue_op;
            rd_q <= bus.issue_rd;
         end
         if (state_next != state) begin
            count <= '0;
         end else if ((state == MUL) || (state == ADD)) begin
            count <= count + 1'b1;
         end
         if (set_illegal) illegal_q <= 1'b1;
         if (set_timeout) timeout_q <= 1'b1;
      end
   end

   // Outputs are decoded from state only (plus the issue operands for ready),
   // so a write to register 0 is suppressed by gating the strobe.
   assign bus.issue_ready = ready;
   assign bus.stall       = bus.issue_valid & ~ready;
   assign bus.mul_start   = (state == MUL) & (count == '0);
   assign bus.add_start   = (state == ADD) & (count == '0);
   assign bus.add_sel_c   = (state == ADD) & (op_q == OP_FMAC);
   assign bus.wb_en       = (state == WB) & (rd_q != 5'd0);
   assign bus.wb_rd       = (state == WB) ? rd_q : 5'd0;
   assign bus.busy        = (state != IDLE);
   assign bus.err_illegal = illegal_q;
   assign bus.err_timeout = timeout_q;

endmodule

// File: tb/tb_fp_mac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_mac_ctrl
// Self-checking bench for fp_mac_ctrl (TIMEOUT = 16). Unit models answer
// each start pulse with a done after a programmable delay (negative = never).
// Expected write-backs (register and cycle) are queued when an instruction
// is accepted and popped when wb_en is seen. A vector table covers the
// basic operations; hand-written sequences cover back-to-back issue,
// hazards, timeouts, stray done pulses and reset during an operation.
// ---------------------------------------------------------------------------
module tb_fp_mac_ctrl;

   localparam logic [1:0] OP_FADD = 2'b00;
   localparam logic [1:0] OP_FMUL = 2'b01;
   localparam logic [1:0] OP_FMAC = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef struct {
      logic [4:0] rd;
      int         due;
   } sb_t;

   typedef struct {
      logic [1:0] op;
      logic [4:0] rd;
      int         mlat;
      int         alat;
      logic       exp_mul_start;
      logic       exp_add_start;
      logic       exp_busy;
      logic       exp_illegal;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   fp_mac_ctrl_if bus();

   fp_mac_ctrl #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         cyc        = 0;
   int         compared   = 0;
   int         mismatched = 0;
   int         mul_lat    = 0;
   int         add_lat    = 0;
   int         mul_wait   = -1;
   int         add_wait   = -1;
   logic [1:0] cur_op     = 2'b00;
   sb_t        sb_q[$];
   vec_t       vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int latency(input logic [1:0] op);
      case (op)
         OP_FADD: return 2 + add_lat;
         OP_FMUL: return 2 + mul_lat;
         OP_FMAC: return 3 + mul_lat + add_lat;
         default: return 0;
      endcase
   endfunction

   function automatic bit expects_wb(input logic [1:0] op, input logic [4:0] rd);
      if (rd == 5'd0) return 1'b0;
      case (op)
         OP_FADD: return add_lat >= 0;
         OP_FMUL: return mul_lat >= 0;
         OP_FMAC: return (mul_lat >= 0) && (add_lat >= 0);
         default: return 1'b0;
      endcase
   endfunction

   // One cycle: wait for the falling edge, check write-back against the
   // scoreboard, then let the unit models drive done for the next edge.
   task automatic tick();
      sb_t e;
      @(negedge clk);
      cyc++;
      if (bus.wb_en === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("wb_unexpected", 32'(bus.wb_en), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
            check("wb_cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (bus.add_start === 1'b1)
         check("add_sel_c", 32'(bus.add_sel_c), 32'(cur_op == OP_FMAC));
      bus.mul_done = 1'b0;
      bus.add_done = 1'b0;
      if (bus.mul_start === 1'b1) mul_wait = mul_lat;
      if (bus.add_start === 1'b1) add_wait = add_lat;
      if (mul_wait == 0) bus.mul_done = 1'b1;
      if (add_wait == 0) bus.add_done = 1'b1;
      if (mul_wait >= 0) mul_wait--;
      if (add_wait >= 0) add_wait--;
   endtask

   // Offer an instruction until accepted; returns the acceptance cycle and
   // the number of cycles stall was seen high while waiting.
   task automatic applyStimulus(input logic [1:0] op, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt,
                                output int acc_cyc, output int stall_cnt);
      sb_t e;
      bit  acc;
      acc       = 1'b0;
      acc_cyc   = -1;
      stall_cnt = 0;
      bus.issue_valid = 1'b1;
      bus.issue_op    = op;
      bus.issue_rd    = rd;
      bus.issue_rs    = rs;
      bus.issue_rt    = rt;
      for (int c = 0; c < 60 && !acc; c++) begin
         #1;
         if (bus.stall === 1'b1) stall_cnt++;
         if (bus.issue_ready === 1'b1) begin
            acc     = 1'b1;
            acc_cyc = cyc;
            cur_op  = op;
            if (expects_wb(op, rd)) begin
               e.rd  = rd;
               e.due = cyc + latency(op);
               sb_q.push_back(e);
            end
         end
         tick();
      end
      bus.issue_valid = 1'b0;
      if (!acc) check("issue_accept_timeout", 32'(bus.issue_ready), 32'd1);
   endtask

   task automatic waitIdle(output int idle_cyc);
      idle_cyc = -1;
      for (int c = 0; c < 60; c++) begin
         if (bus.busy === 1'b0) begin
            idle_cyc = cyc;
            break;
         end
         tick();
      end
      if (idle_cyc < 0) check("idle_wait_timeout", 32'(bus.busy), 32'd0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, act, exp);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n, m, st, idle;

      vecs[0] = '{OP_FADD, 5'd3,  0,  1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{OP_FMUL, 5'd5,  0,  0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{OP_FMAC, 5'd7,  2,  1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{OP_FADD, 5'd0,  0,  0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{OP_FMAC, 5'd31, 0,  0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{OP_FMUL, 5'd12, 3,  0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{OP_RSVD, 5'd4,  0,  0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{OP_FADD, 5'd8,  0,  2, 1'b0, 1'b1, 1'b1, 1'b1};

      reset           = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_op    = 2'b00;
      bus.issue_rd    = 5'd0;
      bus.issue_rs    = 5'd0;
      bus.issue_rt    = 5'd0;
      bus.mul_done    = 1'b0;
      bus.add_done    = 1'b0;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_outputs", 32'({bus.mul_start, bus.add_start, bus.wb_en, bus.busy,
                                     bus.err_illegal, bus.err_timeout, bus.add_sel_c}), 32'd0);
      checkOutput("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
      checkOutput("rst_ready", 32'(bus.issue_ready), 32'd1);
      reset = 1'b1;
      tick();

      // Table-driven single instructions
      for (int i = 0; i < 8; i++) begin
         mul_lat = vecs[i].mlat;
         add_lat = vecs[i].alat;
         applyStimulus(vecs[i].op, vecs[i].rd, 5'd1, 5'd2, n, st);
         checkOutput("vec_start_busy", 32'({bus.mul_start, bus.add_start, bus.busy}),
                     32'({vecs[i].exp_mul_start, vecs[i].exp_add_start, vecs[i].exp_busy}));
         checkOutput("vec_err_illegal", 32'(bus.err_illegal), 32'(vecs[i].exp_illegal));
         waitIdle(idle);
         checkOutput("vec_idle_cycle", 32'(idle), 32'(n + latency(vecs[i].op) + 1));
         checkOutput("vec_sb_drained", 32'(sb_q.size()), 32'd0);
      end
      checkOutput("no_timeout_yet", 32'(bus.err_timeout), 32'd0);

      // FMAC with a second instruction held by stall until WB
      mul_lat = 2;
      add_lat = 1;
      applyStimulus(OP_FMAC, 5'd7, 5'd1, 5'd2, n, st);
      applyStimulus(OP_FADD, 5'd9, 5'd3, 5'd4, m, st);
      checkOutput("fmac_second_accept", 32'(m), 32'(n + 6));
      checkOutput("fmac_stall_cycles", 32'(st), 32'd5);
      waitIdle(idle);
      checkOutput("fmac_sb_drained", 32'(sb_q.size()), 32'd0);

      // Hazard on rs: not accepted in WB, one bubble
      mul_lat = 0;
      add_lat = 0;
      applyStimulus(OP_FMUL, 5'd5, 5'd1, 5'd2, n, st);
      applyStimulus(OP_FADD, 5'd6, 5'd5, 5'd1, m, st);
      checkOutput("haz_rs_accept", 32'(m), 32'(n + 3));
      checkOutput("haz_rs_stall", 32'(st), 32'd2);
      waitIdle(idle);

      // Hazard on rt
      applyStimulus(OP_FMUL, 5'd5, 5'd1, 5'd2, n, st);
      applyStimulus(OP_FADD, 5'd6, 5'd2, 5'd5, m, st);
      checkOutput("haz_rt_accept", 32'(m), 32'(n + 3));
      waitIdle(idle);

      // Independent sources: accepted in WB with no bubble
      applyStimulus(OP_FMUL, 5'd5, 5'd1, 5'd2, n, st);
      applyStimulus(OP_FADD, 5'd10, 5'd4, 5'd6, m, st);
      checkOutput("nohaz_accept", 32'(m), 32'(n + 2));
      checkOutput("nohaz_stall", 32'(st), 32'd1);
      waitIdle(idle);
      checkOutput("haz_sb_drained", 32'(sb_q.size()), 32'd0);

      // Multiplier never answers: back to IDLE 16 cycles after mul_start
      mul_lat = -1;
      applyStimulus(OP_FMUL, 5'd11, 5'd1, 5'd2, n, st);
      repeat (15) tick();
      checkOutput("tmo_busy_last", 32'({bus.busy, bus.err_timeout}), 32'b10);
      tick();
      checkOutput("tmo_idle", 32'({bus.busy, bus.err_timeout}), 32'b01);
      checkOutput("tmo_cycle", 32'(cyc), 32'(n + 17));

      // Adder never answers
      mul_lat = 0;
      add_lat = -1;
      applyStimulus(OP_FADD, 5'd12, 5'd1, 5'd2, n, st);
      waitIdle(idle);
      checkOutput("tmo_add_idle", 32'(idle), 32'(n + 17));
      checkOutput("tmo_sb_drained", 32'(sb_q.size()), 32'd0);

      // Stray add_done while in MUL must be ignored
      mul_lat = 3;
      add_lat = 0;
      applyStimulus(OP_FMUL, 5'd13, 5'd1, 5'd2, n, st);
      add_wait = 0;
      waitIdle(idle);
      checkOutput("stray_idle", 32'(idle), 32'(n + 6));
      checkOutput("stray_sb_drained", 32'(sb_q.size()), 32'd0);

      // Reset during ADD, with add_done arriving in the reset cycle
      mul_lat = 0;
      add_lat = 2;
      applyStimulus(OP_FADD, 5'd9, 5'd1, 5'd2, n, st);
      tick();
      tick();
      reset = 1'b0;
      tick();
      checkOutput("rst_mid_outputs", 32'({bus.mul_start, bus.add_start, bus.wb_en, bus.busy,
                                         bus.err_illegal, bus.err_timeout, bus.add_sel_c}), 32'd0);
      checkOutput("rst_mid_ready", 32'(bus.issue_ready), 32'd1);
      reset = 1'b1;
      tick();
      checkOutput("rst_mid_no_wb", 32'(sb_q.size()), 32'd1);
      sb_q.delete();

      // Operation after reset
      mul_lat = 1;
      add_lat = 0;
      applyStimulus(OP_FMAC, 5'd20, 5'd1, 5'd2, n, st);
      waitIdle(idle);
      checkOutput("post_rst_idle", 32'(idle), 32'(n + 5));
      checkOutput("post_rst_sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fp_mac_ctrl.md
FP_MAC_CTRL -- requirements
Module: fp_mac_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum cycles the controller waits for a unit done in MUL or ADD.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset==0 at a rising clk edge resets the block.
REQ-004 issue_valid  input  1  decode stage presents an FP instruction.
REQ-005 issue_op  input  2  operation: 00 FADD, 01 FMUL, 10 FMAC (a*b+c), 11 reserved.
REQ-006 issue_rd / issue_rs / issue_rt  input  5 each  destination and source register numbers.
REQ-007 issue_ready  output  1  the controller accepts the instruction this cycle.
REQ-008 stall  output  1  freezes PC and IF/ID; equals issue_valid & ~issue_ready.
REQ-009 mul_start / add_start  output  1 each  one-cycle start pulses to the FP multiplier and the FP adder.
REQ-010 mul_done / add_done  input  1 each  unit result valid, a one-cycle pulse.
REQ-011 add_sel_c  output  1  adder operand-B select: 1 selects c (FMAC), 0 selects b.
REQ-012 wb_en  output  1; wb_rd  output  5  register-file write strobe and destination.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 err_illegal / err_timeout  output  1 each  sticky error flags.

Function
REQ-015 States are IDLE, MUL, ADD and WB; the state register is the only sequencing element besides the latched op/rd and the timeout counter.
REQ-016 Acceptance occurs when issue_valid & issue_ready are both high at a rising edge.
- op and rd are latched on acceptance.
- issue_ready = (state==IDLE) | (state==WB & issue_rs!=wb_rd & issue_rt!=wb_rd).
REQ-017 Transitions on acceptance:
- FADD -> ADD
- FMUL -> MUL
- FMAC -> MUL
- reserved -> IDLE, with err_illegal set and no start pulse.
REQ-018 The corresponding start pulse is high exactly in the first cycle of MUL or ADD.
REQ-019 In MUL, mul_done=1 moves the state to ADD for FMAC, or to WB for FMUL.
REQ-020 In ADD, add_done=1 moves the state to WB, and add_sel_c=1 throughout ADD when the latched op is FMAC.
REQ-021 A done pulse is honoured in any cycle of its state, including the start cycle; done from the non-active unit is ignored.
REQ-022 WB lasts exactly one cycle with wb_rd = latched rd.
- wb_en = 1 unless latched rd == 0, in which case wb_en = 0 and no write to $0 occurs.
- Next state is the accepted op's state if an issue is accepted in WB, else IDLE.
REQ-023 Minimum latency from acceptance edge N to wb_en: FADD/FMUL wb_en at cycle N+2; FMAC wb_en at cycle N+3.
REQ-024 Timeout counter (clog2(TIMEOUT) bits):
- cleared on entry to MUL or ADD;
- increments each cycle without done;
- at count TIMEOUT-1 without done, next state is IDLE, err_timeout is set, and no WB occurs.
REQ-025 Done and the timeout limit in the same cycle: done wins.
REQ-026 err_illegal and err_timeout stay set until reset.
REQ-027 issue_valid while busy and not in WB produces stall=1; the instruction is held by the pipeline and not lost.

Reset
REQ-028 On reset==0 at a rising edge, state is IDLE, the counter is 0 and the latched op/rd are 0.
- Outputs: mul_start, add_start, wb_en, busy, err_illegal, err_timeout, add_sel_c = 0; wb_rd = 0.
- issue_ready = 1 the following cycle.
REQ-029 Reset mid-operation (any state) aborts without wb_en; a done pulse arriving in the reset cycle is ignored.

Verification
REQ-030 FADD rd=3 at cycle 0, add_done at cycle 2 -> add_start=1 at cycle 1, wb_en=1 with wb_rd=3 at cycle 3, busy=0 at cycle 4.
REQ-031 FMAC rd=7, mul_done 2 cycles and add_done 1 cycle after their starts -> add_sel_c=1 during ADD, wb_en at acceptance+6, stall=1 for a second issue held throughout.
REQ-032 FMUL rd=5 followed in WB by FADD with rs=5 -> issue_ready=0 in WB, acceptance one cycle later; followed instead by rs=4, rt=6 -> accepted in WB with no bubble.
REQ-033 FMUL with mul_done never asserted, TIMEOUT=16 -> IDLE 16 cycles after mul_start, err_timeout=1, wb_en never 1.
REQ-034 op=11 -> err_illegal=1 next cycle, no start pulse; FADD rd=0 -> wb_en stays 0 in WB.
REQ-035 reset=0 during ADD -> IDLE next cycle, all outputs 0, sticky flags cleared, issue_ready=1 next cycle.
